// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece datapath.
package tetris_pkg;
  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2
  } move_t;
endpackage

// File: rtl/move_request_gen_if.sv
// Move request handshake between the request generator and the position updater.
interface move_request_gen_if;
  import tetris_pkg::*;
  logic  en_o;
  logic  ready_i;
  move_t movement_o;

  modport master (output en_o, output movement_o, input ready_i);
  modport slave  (input en_o, input movement_o, output ready_i);
endinterface

// File: rtl/move_request_gen.sv
// Turns raw buttons and frame ticks into one-at-a-time move requests:
// sync + edge detect, gravity/soft drop, horizontal DAS/auto-repeat.
module move_request_gen
  import tetris_pkg::*;
#(
  parameter int DROP_TICKS   = 30,
  parameter int SOFT_TICKS   = 2,
  parameter int DAS_TICKS    = 10,
  parameter int REPEAT_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               down_i,
  input  logic               halt_i,
  move_request_gen_if.master mv
);

  localparam int GMAX = (DROP_TICKS > SOFT_TICKS) ? DROP_TICKS : SOFT_TICKS;
  localparam int HMAX = (DAS_TICKS > REPEAT_TICKS) ? DAS_TICKS : REPEAT_TICKS;
  localparam int GW   = $clog2(GMAX + 1);
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_REPEAT} hstate_t;

  logic left_p0, left_p1, left_p2;
  logic right_p0, right_p1, right_p2;
  logic down_p0, down_p1, down_p2;
  logic left_rise, right_rise, down_rise;

  logic [GW-1:0] gcnt;
  logic [GW-1:0] gperiod_m1;
  logic          grav_wrap, set_down;

  hstate_t       state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt, hcnt_inc, hterm;
  logic          hdir, hdir_nxt;
  logic          one_held, cur_dir, set_h;

  logic pend_down, pend_left, pend_right;
  logic any_pend, en;
  logic iss_down, iss_left, iss_right;

  // Stage p0/p1: two-flop synchroniser; p2: previous synced level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      {left_p0, left_p1, left_p2}    <= '0;
      {right_p0, right_p1, right_p2} <= '0;
      {down_p0, down_p1, down_p2}    <= '0;
    end else begin
      {left_p0, left_p1, left_p2}    <= {left_i, left_p0, left_p1};
      {right_p0, right_p1, right_p2} <= {right_i, right_p0, right_p1};
      {down_p0, down_p1, down_p2}    <= {down_i, down_p0, down_p1};
    end
  end

  assign left_rise  = left_p1 & ~left_p2;
  assign right_rise = right_p1 & ~right_p2;
  assign down_rise  = down_p1 & ~down_p2;

  // A shorter period taking effect mid-count wraps on the next tick via >=
  assign gperiod_m1 = down_p1 ? GW'(SOFT_TICKS - 1) : GW'(DROP_TICKS - 1);
  assign grav_wrap  = tick_i & ~down_rise & (gcnt >= gperiod_m1);
  assign set_down   = ~halt_i & (down_rise | grav_wrap);

  always_ff @(posedge clk) begin
    if (rst || halt_i || down_rise) begin
      gcnt <= '0;
    end else if (tick_i) begin
      gcnt <= grav_wrap ? '0 : gcnt + 1'b1;
    end
  end

  assign one_held = left_p1 ^ right_p1;
  assign cur_dir  = right_p1;
  assign hcnt_inc = hcnt + 1'b1;
  assign hterm    = (state == H_DAS) ? HW'(DAS_TICKS) : HW'(REPEAT_TICKS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= H_IDLE;
      hcnt  <= '0;
      hdir  <= 1'b0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      hdir  <= hdir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    hdir_nxt  = hdir;
    set_h     = 1'b0;
    if (halt_i) begin
      state_nxt = H_IDLE;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        H_IDLE: begin
          if ((left_rise | right_rise) && one_held) begin
            set_h     = 1'b1;
            hdir_nxt  = cur_dir;
            hcnt_nxt  = '0;
            state_nxt = H_DAS;
          end
        end
        H_DAS, H_REPEAT: begin
          if (!one_held || (cur_dir != hdir)) begin
            state_nxt = H_IDLE;
            hcnt_nxt  = '0;
          end else if (tick_i) begin
            if (hcnt_inc == hterm) begin
              set_h     = 1'b1;
              hcnt_nxt  = '0;
              state_nxt = H_REPEAT;
            end else begin
              hcnt_nxt = hcnt_inc;
            end
          end
        end
        default: begin
          state_nxt = H_IDLE;
          hcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign any_pend  = pend_down | pend_left | pend_right;
  assign en        = any_pend & mv.ready_i & ~halt_i;
  assign iss_down  = en & pend_down;
  assign iss_left  = en & ~pend_down & pend_left;
  assign iss_right = en & ~pend_down & ~pend_left & pend_right;

  // Set beats clear when both land on the same edge
  always_ff @(posedge clk) begin
    if (rst || halt_i) begin
      pend_down  <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
    end else begin
      pend_down  <= set_down | (pend_down & ~iss_down);
      pend_left  <= (set_h & ~hdir_nxt) | (pend_left & ~iss_left);
      pend_right <= (set_h & hdir_nxt) | (pend_right & ~iss_right);
    end
  end

  always_comb begin
    mv.movement_o = DOWN;
    if (pend_down)       mv.movement_o = DOWN;
    else if (pend_left)  mv.movement_o = LEFT;
    else if (pend_right) mv.movement_o = RIGHT;
  end

  assign mv.en_o = en;

endmodule

// File: tb/tb_move_request_gen.sv
// Directed-vector bench for move_request_gen (DROP_TICKS=4, SOFT=2, DAS=10, REPEAT=3).
module tb_move_request_gen;
  import tetris_pkg::*;

  logic clk = 1'b0;
  logic rst, tick_i, left_i, right_i, down_i, halt_i;
  int   checks = 0;
  int   errors = 0;

  move_request_gen_if mv_if();

  move_request_gen #(
    .DROP_TICKS(4), .SOFT_TICKS(2), .DAS_TICKS(10), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .left_i(left_i), .right_i(right_i),
    .down_i(down_i), .halt_i(halt_i), .mv(mv_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, first, bad;
    logic [63:0] rmask, dmask, rexp, dexp;

    rst = 1'b1; tick_i = 1'b0; left_i = 1'b0; right_i = 1'b0; down_i = 1'b0;
    halt_i = 1'b0; mv_if.ready_i = 1'b1;

    // Reset
    step(); step();
    rst = 1'b0;
    check("rst_en", mv_if.en_o, 0);
    check("rst_mov", mv_if.movement_o, DOWN);
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (mv_if.en_o) pulses++;
    end
    check("rst_idle", pulses, 0);

    // Gravity: tick every 5 cycles, wrap every 4th tick
    pulses = 0; first = -1; bad = 0;
    for (int c = 0; c < 80; c++) begin
      tick_i = (c % 5 == 0);
      step();
      if (mv_if.en_o) begin
        pulses++;
        if (first < 0) first = c;
        if (mv_if.movement_o !== DOWN) bad++;
      end
      if (mv_if.en_o !== (c % 20 == 15)) bad++;
    end
    tick_i = 1'b0;
    check("grav_pulses", pulses, 4);
    check("grav_first", first, 15);
    check("grav_shape", bad, 0);

    // Tap left, no ticks
    pulses = 0; first = -1; bad = 0;
    for (int c = 0; c < 30; c++) begin
      left_i = (c < 20);
      step();
      if (mv_if.en_o) begin
        pulses++;
        if (first < 0) first = c;
        if (mv_if.movement_o !== LEFT) bad++;
      end
    end
    check("tap_pulses", pulses, 1);
    check("tap_first", first, 2);
    check("tap_dir", bad, 0);

    // Auto-repeat right with a tick every cycle; gravity interleaves with priority
    rmask = '0; dmask = '0; dexp = '0; bad = 0;
    rexp = 64'h0;
    rexp[2] = 1'b1; rexp[12] = 1'b1; rexp[16] = 1'b1; rexp[18] = 1'b1;
    rexp[21] = 1'b1; rexp[24] = 1'b1; rexp[28] = 1'b1; rexp[30] = 1'b1;
    for (int c = 0; c < 40; c++) if (c % 4 == 3) dexp[c] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      right_i = (c < 30);
      tick_i  = 1'b1;
      step();
      if (mv_if.en_o) begin
        if (mv_if.movement_o == RIGHT) rmask[c] = 1'b1;
        else if (mv_if.movement_o == DOWN) dmask[c] = 1'b1;
        else bad++;
      end
    end
    tick_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (mv_if.en_o) pulses++;
    end
    check("rep_right", rmask, rexp);
    check("rep_down", dmask, dexp);
    check("rep_other", bad, 0);
    check("rep_after", pulses, 0);

    // Backpressure: two left taps and a gravity wrap while not ready
    mv_if.ready_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      left_i = (c < 3) || (c >= 6 && c < 9);
      tick_i = (c >= 12 && c < 16);
      step();
      if (mv_if.en_o) pulses++;
    end
    tick_i = 1'b0;
    check("bp_stall", pulses, 0);
    mv_if.ready_i = 1'b1;
    #1;
    check("bp_en0", mv_if.en_o, 1);
    check("bp_mov0", mv_if.movement_o, DOWN);
    step();
    check("bp_en1", mv_if.en_o, 1);
    check("bp_mov1", mv_if.movement_o, LEFT);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mv_if.en_o) pulses++;
    end
    check("bp_once", pulses, 0);

    // Halt flushes pending LEFT + DOWN
    mv_if.ready_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      left_i = (c < 3);
      tick_i = (c >= 5 && c < 9);
      step();
      if (mv_if.en_o) pulses++;
    end
    tick_i = 1'b0;
    check("halt_pre", pulses, 0);
    mv_if.ready_i = 1'b1;
    #1;
    check("halt_pend", mv_if.en_o, 1);
    halt_i = 1'b1;
    #1;
    check("halt_mask", mv_if.en_o, 0);
    step();
    halt_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (mv_if.en_o) pulses++;
      step();
    end
    check("halt_flush", pulses, 0);

    // Soft drop: press edge issues at once, then a DOWN every 2 ticks while held
    dmask = '0; dexp = '0;
    for (int c = 2; c <= 12; c += 2) dexp[c] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      down_i = (c < 12);
      tick_i = 1'b1;
      step();
      if (mv_if.en_o && mv_if.movement_o == DOWN) dmask[c] = 1'b1;
      if (mv_if.en_o && mv_if.movement_o != DOWN) bad++;
    end
    tick_i = 1'b0;
    check("soft_down", dmask, dexp);
    check("soft_other", bad, 0);

    // Reset mid-operation discards a pending request
    mv_if.ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      left_i = (c < 3);
      step();
    end
    mv_if.ready_i = 1'b1;
    #1;
    check("rstmid_pend", mv_if.en_o, 1);
    mv_if.ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv_if.ready_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (mv_if.en_o) pulses++;
      step();
    end
    check("rstmid_clear", pulses, 0);
    check("rstmid_mov", mv_if.movement_o, DOWN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
